// File: rtl/ant_switch_allocator_if.sv
// Bundle between the ant routing agent/crossbar side and the switch allocator.
// The agent side drives requests and credit returns; the allocator drives
// crossbar selects, input acknowledgements, credit counts and the error flag.
interface ant_switch_allocator_if #(
    parameter int N       = 5,
    parameter int M       = 5,
    parameter int CREDITS = 4
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(CREDITS + 1);

    logic [0:N-1][M-1:0]     i_output_req;
    logic [0:N-1]            i_data_val;
    logic [0:M-1]            i_credit_return;
    logic [0:M-1][SEL_W-1:0] o_xbar_sel;
    logic [0:M-1]            o_xbar_val;
    logic [0:N-1]            o_input_ack;
    logic [0:M-1][CNT_W-1:0] o_credits;
    logic                    o_err;

    modport master (
        output i_output_req,
        output i_data_val,
        output i_credit_return,
        input  o_xbar_sel,
        input  o_xbar_val,
        input  o_input_ack,
        input  o_credits,
        input  o_err
    );

    modport slave (
        input  i_output_req,
        input  i_data_val,
        input  i_credit_return,
        output o_xbar_sel,
        output o_xbar_val,
        output o_input_ack,
        output o_credits,
        output o_err
    );
endinterface

// File: rtl/ant_switch_allocator.sv
// Per-router switch allocator. Each output runs a round-robin arbiter over the
// inputs whose single-flit request targets it, gated by a downstream credit
// counter. Crossbar selects, valids and input acks are registered (one-cycle
// latency); multi-hot requests and credit overflow raise a sticky error.
module ant_switch_allocator #(
    parameter int N       = 5,
    parameter int M       = 5,
    parameter int CREDITS = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ant_switch_allocator_if.slave   bus
);
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(CREDITS + 1);
    localparam int PC_W  = $clog2(M + 1);
    localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST_IN  = SEL_W'(N - 1);

    // Number of set bits in a request vector.
    function automatic logic [PC_W-1:0] popcount(input logic [M-1:0] v);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < M; b++) begin
            cnt = cnt + PC_W'(v[b]);
        end
        return cnt;
    endfunction

    function automatic logic is_onehot(input logic [M-1:0] v);
        return popcount(v) == PC_W'(1);
    endfunction

    function automatic logic is_multihot(input logic [M-1:0] v);
        return popcount(v) > PC_W'(1);
    endfunction

    logic [0:N-1]            req_ok_s;
    logic                    bad_req_s;
    logic [0:M-1]            found_s;
    logic [0:M-1][SEL_W-1:0] win_s;
    logic [0:M-1][SEL_W-1:0] ptr_nxt_s;
    logic [0:N-1]            ack_s;
    logic [0:M-1][CNT_W-1:0] cred_nxt_s;
    logic [0:M-1]            ovf_s;
    logic                    err_nxt_s;

    logic [0:M-1][SEL_W-1:0] ptr_r;
    logic [0:M-1][CNT_W-1:0] cred_r;
    logic [0:M-1][SEL_W-1:0] xbar_sel_r;
    logic [0:M-1]            xbar_val_r;
    logic [0:N-1]            input_ack_r;
    logic                    err_r;

    // Classify each input: valid one-hot requests compete, valid multi-hot ones are errors.
    always_comb begin
        req_ok_s  = '0;
        bad_req_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_ok_s[i] = bus.i_data_val[i] & is_onehot(bus.i_output_req[i]);
            bad_req_s   = bad_req_s | (bus.i_data_val[i] & is_multihot(bus.i_output_req[i]));
        end
    end

    // Round-robin scan per output starting at its pointer; credits must be non-zero.
    always_comb begin
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        logic             hit;
        sum       = '0;
        idx       = '0;
        hit       = 1'b0;
        found_s   = '0;
        win_s     = '0;
        ptr_nxt_s = ptr_r;
        ack_s     = '0;
        for (int j = 0; j < M; j++) begin
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, ptr_r[j]} + (SEL_W + 1)'(k);
                sum = (sum >= N_EXT) ? (sum - N_EXT) : sum;
                idx = sum[SEL_W-1:0];
                hit = ~found_s[j] & (cred_r[j] != '0) & req_ok_s[idx]
                      & bus.i_output_req[idx][j];
                found_s[j] = found_s[j] | hit;
                win_s[j]   = hit ? idx : win_s[j];
            end
            if (found_s[j]) begin
                ptr_nxt_s[j] = (win_s[j] == LAST_IN) ? '0 : (win_s[j] + SEL_W'(1));
            end else begin
                ptr_nxt_s[j] = ptr_r[j];
            end
            for (int i = 0; i < N; i++) begin
                ack_s[i] = ack_s[i] | (found_s[j] & (win_s[j] == SEL_W'(i)));
            end
        end
    end

    // Credit bookkeeping: grant consumes, return frees, both cancel; overflow saturates.
    always_comb begin
        cred_nxt_s = cred_r;
        ovf_s      = '0;
        for (int j = 0; j < M; j++) begin
            case ({found_s[j], bus.i_credit_return[j]})
                2'b10: begin
                    cred_nxt_s[j] = cred_r[j] - CNT_W'(1);
                end
                2'b01: begin
                    if (cred_r[j] == CRED_MAX) begin
                        ovf_s[j]      = 1'b1;
                        cred_nxt_s[j] = cred_r[j];
                    end else begin
                        cred_nxt_s[j] = cred_r[j] + CNT_W'(1);
                    end
                end
                default: begin
                    cred_nxt_s[j] = cred_r[j];
                end
            endcase
        end
        err_nxt_s = err_r | bad_req_s | (|ovf_s);
    end

    // State and output registers; reset drops in-flight grants and refills credits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r       <= '0;
            xbar_sel_r  <= '0;
            xbar_val_r  <= '0;
            input_ack_r <= '0;
            err_r       <= 1'b0;
            for (int j = 0; j < M; j++) begin
                cred_r[j] <= CRED_MAX;
            end
        end else begin
            ptr_r       <= ptr_nxt_s;
            cred_r      <= cred_nxt_s;
            xbar_val_r  <= found_s;
            input_ack_r <= ack_s;
            err_r       <= err_nxt_s;
            for (int j = 0; j < M; j++) begin
                xbar_sel_r[j] <= found_s[j] ? win_s[j] : '0;
            end
        end
    end

    assign bus.o_xbar_sel  = xbar_sel_r;
    assign bus.o_xbar_val  = xbar_val_r;
    assign bus.o_input_ack = input_ack_r;
    assign bus.o_credits   = cred_r;
    assign bus.o_err       = err_r;
endmodule
